sprite_reg_bank: RTL

Parametrised, double-buffered sprite register store and decoder for NUM_SPRITES sprites.
- CPU writes land in a shadow bank.
- A vblank commit copies shadow to the active bank atomically.
- The renderer reads the active bank of one sprite per request, and gets decoded fields one cycle later.
- Sits between the CPU register bus and the sprite renderer. The renderer never sees a torn, mid-frame register update.

---
 rtl/sprite_reg_bank_if.sv | 73 +++++++
 rtl/sprite_reg_bank.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/sprite_reg_bank_if.sv
// Bus bundle for sprite_reg_bank: CPU register port and renderer read port.
// SPRITE_REG_READBACK_EN adds the CPU shadow readback signals.
interface sprite_reg_bank_if #(
   parameter int SPRITE_IDX_WIDTH = 5,
   parameter int REG_DATA_WIDTH   = 16
);
   logic                        wr_en;
   logic [SPRITE_IDX_WIDTH+2:0] wr_addr;
   logic [REG_DATA_WIDTH-1:0]   wr_data;
   logic                        commit;
   logic                        pending;

   logic                        rd_req;
   logic [SPRITE_IDX_WIDTH-1:0] rd_sprite;
   logic                        rd_valid;

   logic                        enabled;
   logic                        enable_scroll;
   logic                        enable_transp;
   logic                        enable_alpha;
   logic                        enable_color;
   logic                        flip_x;
   logic                        flip_y;
   logic                        flip_xy;
   logic [3:0]                  palette;
   logic [15:0]                 width;
   logic [15:0]                 height;

   logic [REG_DATA_WIDTH-1:0]   ctrl0;
   logic [REG_DATA_WIDTH-1:0]   ctrl1;
   logic [REG_DATA_WIDTH-1:0]   data_offset;
   logic [REG_DATA_WIDTH-1:0]   ref_xy;
   logic [REG_DATA_WIDTH-1:0]   color_key;
   logic [REG_DATA_WIDTH-1:0]   offset_x;
   logic [REG_DATA_WIDTH-1:0]   offset_y;

`ifdef SPRITE_REG_READBACK_EN
   logic                        cpu_rd_en;
   logic [SPRITE_IDX_WIDTH+2:0] cpu_rd_addr;
   logic [REG_DATA_WIDTH-1:0]   cpu_rd_data;
   logic                        cpu_rd_valid;
`endif

   modport master (
      output wr_en, wr_addr, wr_data, commit,
      output rd_req, rd_sprite,
`ifdef SPRITE_REG_READBACK_EN
      output cpu_rd_en, cpu_rd_addr,
      input  cpu_rd_data, cpu_rd_valid,
`endif
      input  pending, rd_valid,
      input  enabled, enable_scroll, enable_transp, enable_alpha,
      input  enable_color, flip_x, flip_y, flip_xy,
      input  palette, width, height,
      input  ctrl0, ctrl1, data_offset, ref_xy,
      input  color_key, offset_x, offset_y
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, commit,
      input  rd_req, rd_sprite,
`ifdef SPRITE_REG_READBACK_EN
      input  cpu_rd_en, cpu_rd_addr,
      output cpu_rd_data, cpu_rd_valid,
`endif
      output pending, rd_valid,
      output enabled, enable_scroll, enable_transp, enable_alpha,
      output enable_color, flip_x, flip_y, flip_xy,
      output palette, width, height,
      output ctrl0, ctrl1, data_offset, ref_xy,
      output color_key, offset_x, offset_y
   );
endinterface

// File: rtl/sprite_reg_bank.sv
// Double-buffered sprite register store with a one-stage decoded read port.
// Optional CPU shadow readback is enabled by SPRITE_REG_READBACK_EN.
module sprite_reg_bank #(
   parameter int NUM_SPRITES      = 32,
   parameter int SPRITE_IDX_WIDTH = 5,
   parameter int REG_DATA_WIDTH   = 16,
   parameter int SIZE_FIELD_WIDTH = 2,
   parameter int MIN_SIZE_LOG2    = 3
) (
   input logic                clk,
   input logic                reset,
   sprite_reg_bank_if.slave   bus
);
   localparam int LP_NREG = 7;
   localparam int LP_AW   = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
   localparam int LP_MAX_SHIFT =
      MIN_SIZE_LOG2 + (1 << SIZE_FIELD_WIDTH) - 1;
   localparam logic [SPRITE_IDX_WIDTH:0] LP_NUM =
      NUM_SPRITES[SPRITE_IDX_WIDTH:0];

   if (LP_MAX_SHIFT >= 16) begin : g_bad_size
      $error("sprite_reg_bank: size shift exceeds 15");
   end
   if ((1 << SPRITE_IDX_WIDTH) < NUM_SPRITES) begin : g_bad_idx
      $error("sprite_reg_bank: index too narrow for NUM_SPRITES");
   end
   if (REG_DATA_WIDTH < 12 ||
       REG_DATA_WIDTH < 8 + SIZE_FIELD_WIDTH) begin : g_bad_dw
      $error("sprite_reg_bank: REG_DATA_WIDTH too narrow");
   end

   logic [REG_DATA_WIDTH-1:0] r_shadow [NUM_SPRITES][LP_NREG];
   logic [REG_DATA_WIDTH-1:0] r_active [NUM_SPRITES][LP_NREG];
   logic                      r_pending;

   logic [SPRITE_IDX_WIDTH-1:0] w_wr_spr;
   logic [2:0]                  w_wr_reg;
   logic [LP_AW-1:0]            w_wr_idx;
   logic                        w_wr_ok;

   assign w_wr_spr = bus.wr_addr[SPRITE_IDX_WIDTH+2:3];
   assign w_wr_reg = bus.wr_addr[2:0];
   assign w_wr_idx = w_wr_spr[LP_AW-1:0];
   assign w_wr_ok  = bus.wr_en &&
                     ({1'b0, w_wr_spr} < LP_NUM) &&
                     (w_wr_reg != 3'd7);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int s = 0; s < NUM_SPRITES; s++) begin
            for (int r = 0; r < LP_NREG; r++) begin
               r_shadow[s][r] <= '0;
            end
         end
      end else if (w_wr_ok) begin
         r_shadow[w_wr_idx][w_wr_reg] <= bus.wr_data;
      end
   end

   // Copy sees pre-write shadow, so a same-cycle write waits for the next commit
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int s = 0; s < NUM_SPRITES; s++) begin
            for (int r = 0; r < LP_NREG; r++) begin
               r_active[s][r] <= '0;
            end
         end
      end else if (bus.commit) begin
         for (int s = 0; s < NUM_SPRITES; s++) begin
            for (int r = 0; r < LP_NREG; r++) begin
               r_active[s][r] <= r_shadow[s][r];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pending <= 1'b0;
      end else if (w_wr_ok) begin
         r_pending <= 1'b1;
      end else if (bus.commit) begin
         r_pending <= 1'b0;
      end
   end

   function automatic logic [15:0] f_size(
      input logic [SIZE_FIELD_WIDTH-1:0] i_fld
   );
      return 16'd1 << (MIN_SIZE_LOG2 + int'(i_fld));
   endfunction

   logic [LP_AW-1:0]          w_rd_idx;
   logic                      w_rd_ok;
   logic [REG_DATA_WIDTH-1:0] w_rd_c1;

   assign w_rd_idx = bus.rd_sprite[LP_AW-1:0];
   assign w_rd_ok  = ({1'b0, bus.rd_sprite} < LP_NUM);
   assign w_rd_c1  = r_active[w_rd_idx][1];

   logic                      r_rd_valid;
   logic [REG_DATA_WIDTH-1:0] r_regs [LP_NREG];
   logic [15:0]               r_width;
   logic [15:0]               r_height;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rd_valid <= 1'b0;
         r_width    <= '0;
         r_height   <= '0;
         for (int r = 0; r < LP_NREG; r++) begin
            r_regs[r] <= '0;
         end
      end else begin
         r_rd_valid <= bus.rd_req;
         if (bus.rd_req) begin
            if (w_rd_ok) begin
               for (int r = 0; r < LP_NREG; r++) begin
                  r_regs[r] <= r_active[w_rd_idx][r];
               end
               r_width  <= f_size(w_rd_c1[SIZE_FIELD_WIDTH-1:0]);
               r_height <= f_size(w_rd_c1[8+SIZE_FIELD_WIDTH-1:8]);
            end else begin
               for (int r = 0; r < LP_NREG; r++) begin
                  r_regs[r] <= '0;
               end
               r_width  <= '0;
               r_height <= '0;
            end
         end
      end
   end

   assign bus.pending       = r_pending;
   assign bus.rd_valid      = r_rd_valid;
   assign bus.ctrl0         = r_regs[0];
   assign bus.ctrl1         = r_regs[1];
   assign bus.data_offset   = r_regs[2];
   assign bus.ref_xy        = r_regs[3];
   assign bus.color_key     = r_regs[4];
   assign bus.offset_x      = r_regs[5];
   assign bus.offset_y      = r_regs[6];
   assign bus.enabled       = r_regs[0][0];
   assign bus.enable_scroll = r_regs[0][1];
   assign bus.enable_transp = r_regs[0][2];
   assign bus.enable_alpha  = r_regs[0][3];
   assign bus.enable_color  = r_regs[0][4];
   assign bus.flip_x        = r_regs[0][5];
   assign bus.flip_y        = r_regs[0][6];
   assign bus.flip_xy       = r_regs[0][7];
   assign bus.palette       = r_regs[0][11:8];
   assign bus.width         = r_width;
   assign bus.height        = r_height;

`ifdef SPRITE_REG_READBACK_EN
   logic [SPRITE_IDX_WIDTH-1:0] w_cr_spr;
   logic [2:0]                  w_cr_reg;
   logic [LP_AW-1:0]            w_cr_idx;
   logic                        w_cr_ok;
   logic                        r_cr_valid;
   logic [REG_DATA_WIDTH-1:0]   r_cr_data;

   assign w_cr_spr = bus.cpu_rd_addr[SPRITE_IDX_WIDTH+2:3];
   assign w_cr_reg = bus.cpu_rd_addr[2:0];
   assign w_cr_idx = w_cr_spr[LP_AW-1:0];
   assign w_cr_ok  = ({1'b0, w_cr_spr} < LP_NUM) &&
                     (w_cr_reg != 3'd7);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cr_valid <= 1'b0;
         r_cr_data  <= '0;
      end else begin
         r_cr_valid <= bus.cpu_rd_en;
         if (bus.cpu_rd_en) begin
            r_cr_data <= w_cr_ok ? r_shadow[w_cr_idx][w_cr_reg] : '0;
         end
      end
   end

   assign bus.cpu_rd_valid = r_cr_valid;
   assign bus.cpu_rd_data  = r_cr_data;
`endif
endmodule
